// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS constants and sync-state encoding for the per-channel
// front end, the QoS selector and the channel FIFOs.
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ts_sync_state_e;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ts_activity_timer.sv
// Idle timer for one TS input: signal_present rises the cycle after any valid
// byte and falls once valid has been low for TIMEOUT_CYCLES clocks.
module ts_activity_timer #(
    parameter int TIMEOUT_CYCLES = 2700,
    parameter int TMR_W          = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    output logic signal_present
);

    localparam logic [TMR_W-1:0] TIMEOUT = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] timer_reg;
    logic [TMR_W-1:0] timer_next;
    logic             present_reg;
    logic             present_next;

    always_comb begin
        timer_next   = timer_reg;
        present_next = present_reg;
        if (valid) begin
            timer_next   = '0;
            present_next = 1'b1;
        end else begin
            if (timer_reg != TIMEOUT) begin
                timer_next = timer_reg + TMR_W'(1);
            end
            if (timer_next == TIMEOUT) begin
                present_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg   <= '0;
            present_reg <= 1'b0;
        end else begin
            timer_reg   <= timer_next;
            present_reg <= present_next;
        end
    end

    assign signal_present = present_reg;

endmodule

// File: rtl/ts_sync_monitor.sv
// Per-channel TS front end: acquires 188-byte packet alignment, flywheels over
// isolated sync misses, forwards aligned bytes with SOP and reports status.
module ts_sync_monitor
    import ts_pkg::*;
#(
    parameter int SYNC_LOCK      = 3,
    parameter int SYNC_LOSS      = 3,
    parameter int TIMEOUT_CYCLES = 2700,
    parameter int TMR_W          = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] ts_data,
    input  logic       err_clr,
    output logic       valid_out,
    output logic       sop_out,
    output logic [7:0] ts_data_out,
    output logic       in_sync,
    output logic       signal_present,
    output logic [7:0] error_count
);

    localparam logic [7:0] POS_LAST  = 8'(TS_PKT_LEN - 1);
    localparam logic [3:0] LOCK_CNT  = 4'(SYNC_LOCK);
    localparam logic [3:0] LOSS_CNT  = 4'(SYNC_LOSS);

    ts_sync_state_e state_reg;
    ts_sync_state_e state_next;
    logic [7:0]     pos_reg;
    logic [7:0]     pos_next;
    logic [3:0]     good_cnt_reg;
    logic [3:0]     good_cnt_next;
    logic [3:0]     miss_cnt_reg;
    logic [3:0]     miss_cnt_next;
    logic [7:0]     err_cnt_reg;
    logic           err_inc;

    logic           valid_out_reg;
    logic           sop_out_reg;
    logic [7:0]     data_out_reg;
    logic           in_sync_reg;

    logic [7:0]     pos_adv;
    logic           is_sync;
    logic           at_sop;
    logic           forward;

    assign pos_adv = (pos_reg == POS_LAST) ? 8'd0 : pos_reg + 8'd1;
    assign is_sync = (ts_data == TS_SYNC_BYTE);
    assign at_sop  = (pos_reg == 8'd0);

    // Sync FSM; everything only moves on valid bytes so idle gaps are invisible.
    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        good_cnt_next = good_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        err_inc       = 1'b0;

        if (valid) begin
            unique case (state_reg)
                HUNT: begin
                    if (is_sync) begin
                        pos_next      = 8'd1;
                        good_cnt_next = 4'd1;
                        state_next    = VERIFY;
                    end
                end

                VERIFY: begin
                    pos_next = pos_adv;
                    if (at_sop) begin
                        if (is_sync) begin
                            good_cnt_next = good_cnt_reg + 4'd1;
                            if (good_cnt_reg + 4'd1 == LOCK_CNT) begin
                                state_next    = LOCKED;
                                miss_cnt_next = 4'd0;
                            end
                        end else begin
                            state_next    = HUNT;
                            good_cnt_next = 4'd0;
                            pos_next      = 8'd0;
                        end
                    end
                end

                LOCKED: begin
                    pos_next = pos_adv;
                    if (at_sop) begin
                        if (is_sync) begin
                            miss_cnt_next = 4'd0;
                        end else begin
                            // Flywheel: keep counting positions through the miss
                            miss_cnt_next = miss_cnt_reg + 4'd1;
                            err_inc       = 1'b1;
                            if (miss_cnt_reg + 4'd1 == LOSS_CNT) begin
                                state_next = HUNT;
                                pos_next   = 8'd0;
                            end
                        end
                    end else if (pos_reg == 8'd1 && ts_data[7]) begin
                        err_inc = 1'b1;
                    end
                end

                default: begin
                    state_next = HUNT;
                    pos_next   = 8'd0;
                end
            endcase
        end
    end

    assign forward = valid && (state_next == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= HUNT;
            pos_reg      <= 8'd0;
            good_cnt_reg <= 4'd0;
            miss_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            good_cnt_reg <= good_cnt_next;
            miss_cnt_reg <= miss_cnt_next;
        end
    end

    // Clear wins over a same-cycle increment; loss of lock leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= 8'd0;
        end else if (err_clr) begin
            err_cnt_reg <= 8'd0;
        end else if (err_inc) begin
            err_cnt_reg <= sat_inc8(err_cnt_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_reg <= 1'b0;
            sop_out_reg   <= 1'b0;
            data_out_reg  <= 8'd0;
            in_sync_reg   <= 1'b0;
        end else begin
            valid_out_reg <= forward;
            sop_out_reg   <= forward && at_sop;
            in_sync_reg   <= (state_next == LOCKED);
            if (forward) begin
                data_out_reg <= ts_data;
            end
        end
    end

    ts_activity_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_activity (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
        .signal_present (signal_present)
    );

    assign valid_out   = valid_out_reg;
    assign sop_out     = sop_out_reg;
    assign ts_data_out = data_out_reg;
    assign in_sync     = in_sync_reg;
    assign error_count = err_cnt_reg;

endmodule

// File: tb/tb_ts_sync_monitor.sv
// Randomised scenario bench for ts_sync_monitor against a packet-level model.
module tb_ts_sync_monitor;
    import ts_pkg::*;

    localparam int SYNC_LOCK = 3;
    localparam int SYNC_LOSS = 3;
    localparam int TIMEOUT   = 2700;
    localparam int PKT       = 188;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] ts_data = 8'd0;
    logic       err_clr = 1'b0;
    logic       valid_out;
    logic       sop_out;
    logic [7:0] ts_data_out;
    logic       in_sync;
    logic       signal_present;
    logic [7:0] error_count;

    int total = 0;
    int bad = 0;
    int pid_ctr = 0;

    ts_sync_monitor #(
        .SYNC_LOCK      (SYNC_LOCK),
        .SYNC_LOSS      (SYNC_LOSS),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TMR_W          (20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
        .ts_data        (ts_data),
        .err_clr        (err_clr),
        .valid_out      (valid_out),
        .sop_out        (sop_out),
        .ts_data_out    (ts_data_out),
        .in_sync        (in_sync),
        .signal_present (signal_present),
        .error_count    (error_count)
    );

    always #5 clk = ~clk;

    // observed vector: {valid_out, sop_out, data[7:0], in_sync, signal_present, err[7:0]}
    logic [19:0] obs;
    assign obs = {valid_out, sop_out, ts_data_out, in_sync, signal_present, error_count};

    // Packet-level model: searching / confirming / locked, offset within packet.
    bit         m_searching;
    bit         m_locked;
    int         m_offset;
    int         m_hits;
    int         m_misses;
    int         m_errs;
    bit         m_vout;
    bit         m_sop;
    logic [7:0] m_data;
    int         m_idle;
    bit         m_seen;

    task automatic model_reset();
        m_searching = 1'b1;
        m_locked    = 1'b0;
        m_offset    = 0;
        m_hits      = 0;
        m_misses    = 0;
        m_errs      = 0;
        m_vout      = 1'b0;
        m_sop       = 1'b0;
        m_data      = 8'd0;
        m_idle      = 0;
        m_seen      = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
        bit inc;
        int pos;
        inc    = 1'b0;
        pos    = m_offset;
        m_vout = 1'b0;
        m_sop  = 1'b0;
        if (v) begin
            m_idle = 0;
            m_seen = 1'b1;
            if (m_searching) begin
                if (d == 8'h47) begin
                    m_searching = 1'b0;
                    m_hits      = 1;
                    m_offset    = 1;
                end
            end else begin
                m_offset = (m_offset + 1) % PKT;
                if (!m_locked) begin
                    if (pos == 0) begin
                        if (d == 8'h47) begin
                            m_hits++;
                            if (m_hits >= SYNC_LOCK) begin
                                m_locked = 1'b1;
                                m_misses = 0;
                            end
                        end else begin
                            m_searching = 1'b1;
                            m_hits      = 0;
                            m_offset    = 0;
                        end
                    end
                end else begin
                    if (pos == 0) begin
                        if (d == 8'h47) begin
                            m_misses = 0;
                        end else begin
                            m_misses++;
                            inc = 1'b1;
                            if (m_misses >= SYNC_LOSS) begin
                                m_locked    = 1'b0;
                                m_searching = 1'b1;
                                m_offset    = 0;
                            end
                        end
                    end else if (pos == 1 && d[7]) begin
                        inc = 1'b1;
                    end
                end
            end
            if (m_locked) begin
                m_vout = 1'b1;
                m_sop  = (pos == 0);
                m_data = d;
            end
        end else if (m_idle < TIMEOUT) begin
            m_idle++;
        end
        if (clr) m_errs = 0;
        else if (inc && m_errs < 255) m_errs++;
    endtask

    function automatic logic [19:0] exp_vec();
        return {m_vout, m_sop, m_data, m_locked, (m_seen && m_idle < TIMEOUT), 8'(m_errs)};
    endfunction

    // Payload never contains 0x47 so acquisition timing is deterministic.
    function automatic logic [7:0] pkt_byte(int pid, int i);
        logic [7:0] r;
        if (i == 0) return 8'h47;
        if (i == 1) r = {3'b000, 5'(pid >> 8)};
        else if (i == 2) r = 8'(pid);
        else r = 8'($urandom);
        if (r == 8'h47) r = 8'h48;
        return r;
    endfunction

    task automatic drive_byte(input bit v, input logic [7:0] d, input bit clr);
        valid   = v;
        ts_data = d;
        err_clr = clr;
        @(posedge clk);
        #1;
        model_step(v, d, clr);
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_state: got %05h want %05h", obs, exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_byte(1'b0, 8'h00, 1'b0);
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle: got %05h want %05h", obs, exp_vec());
        end
    endtask

    task automatic test_lock();
        logic [7:0] d;
        int g;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < PKT; i++) begin
                d = pkt_byte(pid_ctr, i);
                drive_byte(1'b1, d, 1'b0);
                g = p * PKT + i;
                total++;
                if (obs !== exp_vec()) begin
                    bad++;
                    $display("FAIL lock_stream pkt%0d byte%0d: got %05h want %05h", p, i, obs, exp_vec());
                end
                if (g < 376) begin
                    total++;
                    if (valid_out !== 1'b0) begin
                        bad++;
                        $display("FAIL lock_early byte%0d: valid_out=%0b want 0", g, valid_out);
                    end
                end else if (g == 376) begin
                    total++;
                    if ({valid_out, sop_out, ts_data_out, in_sync, error_count} !== {1'b1, 1'b1, 8'h47, 1'b1, 8'h00}) begin
                        bad++;
                        $display("FAIL lock_first: got v=%0b s=%0b d=%02h sync=%0b err=%0d want 1 1 47 1 0",
                                 valid_out, sop_out, ts_data_out, in_sync, error_count);
                    end
                end
            end
            $display("pkt %0d lock: in_sync=%0b err=%0d", pid_ctr, in_sync, error_count);
            pid_ctr++;
        end
    endtask

    task automatic test_flywheel();
        logic [7:0] d;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < PKT; i++) begin
                d = (i == 0 && p == 1) ? 8'h00 : pkt_byte(pid_ctr, i);
                drive_byte(1'b1, d, 1'b0);
                total++;
                if (obs !== exp_vec()) begin
                    bad++;
                    $display("FAIL flywheel_stream pkt%0d byte%0d: got %05h want %05h", p, i, obs, exp_vec());
                end
                if (i == 0 && p == 1) begin
                    total++;
                    if ({valid_out, sop_out, ts_data_out, in_sync, error_count} !== {1'b1, 1'b1, 8'h00, 1'b1, 8'd1}) begin
                        bad++;
                        $display("FAIL flywheel_miss: got v=%0b s=%0b d=%02h sync=%0b err=%0d want 1 1 00 1 1",
                                 valid_out, sop_out, ts_data_out, in_sync, error_count);
                    end
                end else if (i == 0 && p == 2) begin
                    total++;
                    if ({valid_out, sop_out, ts_data_out, in_sync, error_count} !== {1'b1, 1'b1, 8'h47, 1'b1, 8'd1}) begin
                        bad++;
                        $display("FAIL flywheel_next: got v=%0b s=%0b d=%02h sync=%0b err=%0d want 1 1 47 1 1",
                                 valid_out, sop_out, ts_data_out, in_sync, error_count);
                    end
                end
            end
            $display("pkt %0d flywheel: in_sync=%0b err=%0d", pid_ctr, in_sync, error_count);
            pid_ctr++;
        end
    endtask

    task automatic test_loss();
        logic [7:0] d;
        drive_byte(1'b0, 8'h00, 1'b1);
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL loss_clear: got %05h want %05h", obs, exp_vec());
        end
        for (int p = 0; p < 7; p++) begin
            for (int i = 0; i < PKT; i++) begin
                d = (i == 0 && p < 3) ? 8'hB8 : pkt_byte(pid_ctr, i);
                drive_byte(1'b1, d, 1'b0);
                total++;
                if (obs !== exp_vec()) begin
                    bad++;
                    $display("FAIL loss_stream pkt%0d byte%0d: got %05h want %05h", p, i, obs, exp_vec());
                end
                if (i == 0 && p == 2) begin
                    total++;
                    if ({valid_out, in_sync, error_count} !== {1'b0, 1'b0, 8'd3}) begin
                        bad++;
                        $display("FAIL loss_third_miss: got v=%0b sync=%0b err=%0d want 0 0 3",
                                 valid_out, in_sync, error_count);
                    end
                end else if (i == PKT - 1 && p == 4) begin
                    total++;
                    if (in_sync !== 1'b0) begin
                        bad++;
                        $display("FAIL relock_early: in_sync=%0b want 0", in_sync);
                    end
                end else if (i == 0 && p == 5) begin
                    total++;
                    if ({valid_out, sop_out, in_sync} !== 3'b111) begin
                        bad++;
                        $display("FAIL relock: got v=%0b s=%0b sync=%0b want 1 1 1", valid_out, sop_out, in_sync);
                    end
                end
            end
            $display("pkt %0d loss: in_sync=%0b err=%0d", pid_ctr, in_sync, error_count);
            pid_ctr++;
        end
    endtask

    task automatic test_tei();
        logic [7:0] d;
        for (int p = 0; p < 301; p++) begin
            for (int i = 0; i < PKT; i++) begin
                d = (i == 1) ? 8'hC0 : pkt_byte(pid_ctr, i);
                drive_byte(1'b1, d, (p == 300 && i == 1));
                total++;
                if (obs !== exp_vec()) begin
                    bad++;
                    $display("FAIL tei_stream pkt%0d byte%0d: got %05h want %05h", p, i, obs, exp_vec());
                end
                if (p == 299 && i == PKT - 1) begin
                    total++;
                    if (error_count !== 8'd255) begin
                        bad++;
                        $display("FAIL tei_saturate: err=%0d want 255", error_count);
                    end
                end else if (p == 300 && i == 1) begin
                    total++;
                    if (error_count !== 8'd0) begin
                        bad++;
                        $display("FAIL tei_clr_priority: err=%0d want 0", error_count);
                    end
                end
            end
            $display("pkt %0d tei: in_sync=%0b err=%0d", pid_ctr, in_sync, error_count);
            pid_ctr++;
        end
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        int gap;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < PKT; i++) begin
                gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 60)) : 0;
                for (int k = 0; k < gap; k++) begin
                    drive_byte(1'b0, 8'($urandom), 1'b0);
                    total++;
                    if (obs !== exp_vec()) begin
                        bad++;
                        $display("FAIL gap_idle pkt%0d byte%0d: got %05h want %05h", p, i, obs, exp_vec());
                    end
                end
                d = pkt_byte(pid_ctr, i);
                drive_byte(1'b1, d, 1'b0);
                total++;
                if (obs !== exp_vec()) begin
                    bad++;
                    $display("FAIL gap_stream pkt%0d byte%0d: got %05h want %05h", p, i, obs, exp_vec());
                end
            end
            total++;
            if ({in_sync, signal_present} !== 2'b11) begin
                bad++;
                $display("FAIL gap_aligned pkt%0d: sync=%0b present=%0b want 1 1", p, in_sync, signal_present);
            end
            $display("pkt %0d gaps: in_sync=%0b present=%0b", pid_ctr, in_sync, signal_present);
            pid_ctr++;
        end
        for (int k = 1; k <= TIMEOUT; k++) begin
            drive_byte(1'b0, 8'h00, 1'b0);
            if (k == TIMEOUT - 1 || k == TIMEOUT) begin
                total++;
                if (signal_present !== (k == TIMEOUT - 1)) begin
                    bad++;
                    $display("FAIL timeout idle=%0d: present=%0b want %0b", k, signal_present, (k == TIMEOUT - 1));
                end
            end
        end
        for (int i = 0; i < PKT; i++) begin
            drive_byte(1'b1, pkt_byte(pid_ctr, i), 1'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL timeout_resume byte%0d: got %05h want %05h", i, obs, exp_vec());
            end
            if (i == 0) begin
                total++;
                if (signal_present !== 1'b1) begin
                    bad++;
                    $display("FAIL present_return: present=%0b want 1", signal_present);
                end
            end
        end
        $display("pkt %0d resume: in_sync=%0b present=%0b", pid_ctr, in_sync, signal_present);
        pid_ctr++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 90; i++) begin
            drive_byte(1'b1, pkt_byte(pid_ctr, i), 1'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL pre_reset byte%0d: got %05h want %05h", i, obs, exp_vec());
            end
        end
        $display("pkt %0d reset_mid: asserting rst_n at byte 90", pid_ctr);
        pid_ctr++;
        #3;
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs !== 20'h0) begin
            bad++;
            $display("FAIL async_reset: got %05h want 00000", obs);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < PKT; i++) begin
                drive_byte(1'b1, pkt_byte(pid_ctr, i), 1'b0);
                total++;
                if (obs !== exp_vec()) begin
                    bad++;
                    $display("FAIL restart pkt%0d byte%0d: got %05h want %05h", p, i, obs, exp_vec());
                end
                if (p == 0 && i == 0) begin
                    total++;
                    if (dut.state_reg !== VERIFY) begin
                        bad++;
                        $display("FAIL restart_verify: state=%0d want %0d", dut.state_reg, VERIFY);
                    end
                end else if (p == 1 && i == PKT - 1) begin
                    total++;
                    if ({dut.state_reg, in_sync} !== {VERIFY, 1'b0}) begin
                        bad++;
                        $display("FAIL restart_pre_lock: state=%0d sync=%0b want %0d 0", dut.state_reg, in_sync, VERIFY);
                    end
                end else if (p == 2 && i == 0) begin
                    total++;
                    if ({dut.state_reg, in_sync, valid_out} !== {LOCKED, 1'b1, 1'b1}) begin
                        bad++;
                        $display("FAIL restart_lock: state=%0d sync=%0b v=%0b want %0d 1 1",
                                 dut.state_reg, in_sync, valid_out, LOCKED);
                    end
                end
            end
            $display("pkt %0d restart: in_sync=%0b err=%0d", pid_ctr, in_sync, error_count);
            pid_ctr++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_flywheel();
        test_loss();
        test_tei();
        test_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
